// File: rtl/l1ahbmtx_pkg.sv
// Shared AHB encodings and burst helpers for the L1 AHB matrix.
// Used by the output arbiter and its burst tracker.
package l1ahbmtx_pkg;

    localparam int BEAT_W = 4;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    // Remaining beats after the first one; undefined-length INCR is never held.
    function automatic logic [BEAT_W-1:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  burst_beats = 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  burst_beats = 4'd7;
            HBURST_WRAP16, HBURST_INCR16: burst_beats = 4'd15;
            default:                      burst_beats = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/l1ahbmtx_burst_tracker.sv
// Counts remaining beats of a fixed-length burst and requests the grant be held.
// Latency: burst_hold is combinational from the beat being accepted; state moves only when HREADYM=1.
module l1ahbmtx_burst_tracker
    import l1ahbmtx_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       HREADYM,
    input  logic [1:0] HTRANSM,
    input  logic [2:0] HBURSTM,
    input  logic       granted,
    input  logic       holder_req,
    output logic       burst_hold
);

    logic [BEAT_W-1:0] beats_left;
    logic [BEAT_W-1:0] beats_next;
    logic              early_term;

    // Hold follows the count after this beat, so the grant is kept from the
    // first NONSEQ and released on the edge that accepts the last beat.
    always_comb begin
        early_term = (beats_left != '0) && !holder_req;
        beats_next = beats_left;
        if (early_term) begin
            beats_next = '0;
        end else if (granted && (HTRANSM == HTRANS_NONSEQ)) begin
            beats_next = burst_beats(HBURSTM);
        end else if (granted && (HTRANSM == HTRANS_SEQ) && (beats_left != '0)) begin
            beats_next = beats_left - 1'b1;
        end
        burst_hold = (beats_next != '0);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            beats_left <= '0;
        end else if (HREADYM) begin
            beats_left <= beats_next;
        end
    end

endmodule

// File: rtl/l1ahbmtx_output_arbiter.sv
// Round-robin grant of one slave port among NUM_PORTS input stages; L1AHBMTX_FIXED_PRIORITY_EN selects fixed priority.
// Latency: one registered cycle from request to grant; wait states (HREADYM=0) freeze all state.
module l1ahbmtx_output_arbiter
    import l1ahbmtx_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 2
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [PORT_W-1:0]    addr_in_port,
    output logic                 no_port,
    output logic [PORT_W-1:0]    data_in_port,
    output logic                 data_in_valid
);

    logic              burst_hold;
    logic              hold;
    logic              found;
    logic [PORT_W-1:0] start;
    logic [PORT_W-1:0] pick;
    logic [PORT_W-1:0] idx_p;
    int                idx;

    l1ahbmtx_burst_tracker u_burst_tracker (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .HREADYM    (HREADYM),
        .HTRANSM    (HTRANSM),
        .HBURSTM    (HBURSTM),
        .granted    (!no_port),
        .holder_req (req_port[addr_in_port]),
        .burst_hold (burst_hold)
    );

    assign hold = HMASTLOCKM || (HTRANSM == HTRANS_BUSY) || burst_hold;

    // Wrap explicitly at NUM_PORTS so non-power-of-two port counts never skip or alias.
    always_comb begin
`ifdef L1AHBMTX_FIXED_PRIORITY_EN
        start = '0;
`else
        start = ((int'(addr_in_port) + 1) >= NUM_PORTS) ? '0 : addr_in_port + 1'b1;
`endif
        found = 1'b0;
        pick  = addr_in_port;
        idx   = 0;
        idx_p = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(start) + i;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            idx_p = PORT_W'(idx);
            if (!found && req_port[idx_p]) begin
                found = 1'b1;
                pick  = idx_p;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_in_port  <= '0;
            no_port       <= 1'b1;
            data_in_port  <= '0;
            data_in_valid <= 1'b0;
        end else if (HREADYM) begin
            data_in_port  <= addr_in_port;
            data_in_valid <= !no_port && HTRANSM[1];
            if (!hold) begin
                if (found) begin
                    addr_in_port <= pick;
                    no_port      <= 1'b0;
                end else begin
                    no_port      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_l1ahbmtx_output_arbiter.sv
// Directed and randomized bench for l1ahbmtx_output_arbiter against a transaction-level grant model.
module tb_l1ahbmtx_output_arbiter;

    localparam int N = 4;

    logic         HCLK = 1'b0;
    logic         HRESETn;
    logic [N-1:0] req_port;
    logic         HREADYM;
    logic [1:0]   HTRANSM;
    logic [2:0]   HBURSTM;
    logic         HMASTLOCKM;
    logic [1:0]   addr_in_port;
    logic         no_port;
    logic [1:0]   data_in_port;
    logic         data_in_valid;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference state: who owns the slave, how many burst beats are still owed.
    int m_grant;
    bit m_none;
    int m_rem;
    int m_dport;
    bit m_dvld;

    l1ahbmtx_output_arbiter #(.NUM_PORTS(N), .PORT_W(2)) dut (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .req_port      (req_port),
        .HREADYM       (HREADYM),
        .HTRANSM       (HTRANSM),
        .HBURSTM       (HBURSTM),
        .HMASTLOCKM    (HMASTLOCKM),
        .addr_in_port  (addr_in_port),
        .no_port       (no_port),
        .data_in_port  (data_in_port),
        .data_in_valid (data_in_valid)
    );

    always #5 HCLK = ~HCLK;

    function automatic int beats_after_first(input logic [2:0] b);
        int len;
        case (b)
            3'd2, 3'd3: len = 4;
            3'd4, 3'd5: len = 8;
            3'd6, 3'd7: len = 16;
            default:    len = 1;
        endcase
        return len - 1;
    endfunction

    task automatic model_reset();
        m_grant = 0;
        m_none  = 1'b1;
        m_rem   = 0;
        m_dport = 0;
        m_dvld  = 1'b0;
    endtask

    task automatic model_edge();
        int  rem_n;
        int  winner;
        int  p;
        bit  keep;
        if (!HREADYM) return;
        rem_n = m_rem;
        if (m_rem > 0 && !req_port[m_grant]) rem_n = 0;
        else if (!m_none && HTRANSM == 2'b10) rem_n = beats_after_first(HBURSTM);
        else if (!m_none && HTRANSM == 2'b11 && m_rem > 0) rem_n = m_rem - 1;
        keep = HMASTLOCKM || (HTRANSM == 2'b01) || (rem_n > 0);
        m_dport = m_grant;
        m_dvld  = !m_none && HTRANSM[1];
        if (!keep) begin
            winner = -1;
            for (int k = 0; k < N; k++) begin
`ifdef L1AHBMTX_FIXED_PRIORITY_EN
                p = k;
`else
                p = (m_grant + 1 + k) % N;
`endif
                if (winner < 0 && req_port[p]) winner = p;
            end
            if (winner >= 0) begin
                m_grant = winner;
                m_none  = 1'b0;
            end else begin
                m_none  = 1'b1;
            end
        end
        m_rem = rem_n;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [1:0] eg;
        logic [1:0] ed;
        eg = m_grant[1:0];
        ed = m_dport[1:0];
        check({tag, ".addr"}, 32'(addr_in_port), 32'(eg));
        check({tag, ".none"}, 32'(no_port), 32'(m_none));
        check({tag, ".dport"}, 32'(data_in_port), 32'(ed));
        check({tag, ".dvld"}, 32'(data_in_valid), 32'(m_dvld));
    endtask

    task automatic step(input logic [N-1:0] r, input logic rdy, input logic [1:0] tr,
                        input logic [2:0] bu, input logic lk, input string tag);
        req_port   = r;
        HREADYM    = rdy;
        HTRANSM    = tr;
        HBURSTM    = bu;
        HMASTLOCKM = lk;
        @(posedge HCLK);
        model_edge();
        #1;
        check_model(tag);
    endtask

    initial begin
        HRESETn    = 1'b0;
        req_port   = '0;
        HREADYM    = 1'b1;
        HTRANSM    = 2'b00;
        HBURSTM    = 3'b000;
        HMASTLOCKM = 1'b0;
        model_reset();
        repeat (2) @(posedge HCLK);
        #1;
        check("reset.addr", 32'(addr_in_port), 32'd0);
        check("reset.none", 32'(no_port), 32'd1);
        check("reset.dvld", 32'(data_in_valid), 32'd0);
        HRESETn = 1'b1;

`ifndef L1AHBMTX_FIXED_PRIORITY_EN
        // All four request SINGLE transfers: grant rotates 1,2,3,0,1.
        step(4'b1111, 1'b1, 2'b00, 3'd0, 1'b0, "rr0");
        check("rr.first", 32'(addr_in_port), 32'd1);
        step(4'b1111, 1'b1, 2'b10, 3'd0, 1'b0, "rr1");
        check("rr.second", 32'(addr_in_port), 32'd2);
        check("rr.dlag", 32'(data_in_port), 32'd1);
        step(4'b1111, 1'b1, 2'b10, 3'd0, 1'b0, "rr2");
        check("rr.third", 32'(addr_in_port), 32'd3);
        step(4'b1111, 1'b1, 2'b10, 3'd0, 1'b0, "rr3");
        check("rr.wrap", 32'(addr_in_port), 32'd0);
        step(4'b1111, 1'b1, 2'b10, 3'd0, 1'b0, "rr4");
        check("rr.fifth", 32'(addr_in_port), 32'd1);
        step(4'b1111, 1'b1, 2'b10, 3'd0, 1'b0, "rr5");

        // Port 2 INCR8: held through all 8 beats, moves to 3 on the last.
        step(4'b1111, 1'b1, 2'b10, 3'd5, 1'b0, "incr8.ns");
        check("incr8.hold0", 32'(addr_in_port), 32'd2);
        for (int b = 1; b < 7; b++) begin
            step(4'b1111, 1'b1, 2'b11, 3'd5, 1'b0, "incr8.seq");
            check("incr8.hold", 32'(addr_in_port), 32'd2);
        end
        step(4'b1111, 1'b1, 2'b11, 3'd5, 1'b0, "incr8.last");
        check("incr8.release", 32'(addr_in_port), 32'd3);

        // Locked sequence on port 1.
        step(4'b0010, 1'b1, 2'b10, 3'd0, 1'b0, "lock.get");
        check("lock.granted", 32'(addr_in_port), 32'd1);
        for (int t = 0; t < 3; t++) begin
            step(4'b1111, 1'b1, 2'b10, 3'd0, 1'b1, "lock.xfer");
            check("lock.held", 32'(addr_in_port), 32'd1);
        end
        step(4'b1101, 1'b1, 2'b00, 3'd0, 1'b0, "lock.idle");
        check("lock.release", 32'(addr_in_port), 32'd2);

        // Wait states freeze everything while requests churn.
        for (int w = 0; w < 4; w++) begin
            step(4'($urandom_range(0, 15)), 1'b0, 2'b10, 3'd0, 1'b0, "wait");
            check("wait.frozen", 32'(addr_in_port), 32'd2);
        end
        step(4'b0001, 1'b1, 2'b10, 3'd0, 1'b0, "wait.resume");
        check("wait.resumed", 32'(addr_in_port), 32'd0);

        // Port 0 WRAP4 abandoned after two beats.
        step(4'b1111, 1'b1, 2'b10, 3'd2, 1'b0, "wrap4.ns");
        check("wrap4.hold0", 32'(addr_in_port), 32'd0);
        step(4'b1111, 1'b1, 2'b11, 3'd2, 1'b0, "wrap4.seq");
        check("wrap4.hold1", 32'(addr_in_port), 32'd0);
        step(4'b1110, 1'b1, 2'b00, 3'd2, 1'b0, "wrap4.drop");
        check("wrap4.early", 32'(addr_in_port), 32'd1);
`else
        for (int t = 0; t < 6; t++) begin
            step(4'b1010, 1'b1, (t == 0) ? 2'b00 : 2'b10, 3'd0, 1'b0, "fixed");
            check("fixed.grant", 32'(addr_in_port), 32'd1);
        end
`endif

        // Reset asserted mid-burst with five beats still owed.
        step(4'b1111, 1'b1, 2'b10, 3'd0, 1'b0, "mid.pre");
        step(4'b1111, 1'b1, 2'b10, 3'd5, 1'b0, "mid.ns");
        step(4'b1111, 1'b1, 2'b11, 3'd5, 1'b0, "mid.seq1");
        step(4'b1111, 1'b1, 2'b11, 3'd5, 1'b0, "mid.seq2");
        #2;
        HRESETn = 1'b0;
        #1;
        check("arst.none", 32'(no_port), 32'd1);
        check("arst.dvld", 32'(data_in_valid), 32'd0);
        check("arst.addr", 32'(addr_in_port), 32'd0);
        model_reset();
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        step(4'b1111, 1'b1, 2'b00, 3'd0, 1'b0, "arst.fresh");
`ifndef L1AHBMTX_FIXED_PRIORITY_EN
        check("arst.rearb", 32'(addr_in_port), 32'd1);
`endif
        step(4'b1111, 1'b1, 2'b10, 3'd0, 1'b0, "arst.next");

        // Randomized traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            logic [1:0] tr;
            tr = m_none ? 2'b00 : 2'($urandom_range(0, 3));
            step(4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0),
                 tr,
                 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 9) == 0),
                 "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/l1ahbmtx_output_arbiter.md
Name: l1ahbmtx_output_arbiter

Overview:
Per-slave-port arbiter for the L1 AHB matrix output stage. It shares one slave-side AHB port among NUM_PORTS matrix input stages, using round-robin order. The output stage muxes address/control using the registered address-phase grant, and read/write data using the registered data-phase grant. Grants are held for locked sequences and fixed-length bursts; otherwise the arbiter re-arbitrates on every completed slave transfer.

Parameters:
NUM_PORTS, 4, number of input stages competing for this slave port (2..16)
PORT_W, 2, width of port index; equals clog2(NUM_PORTS), minimum 1

Ports:
HCLK  input  1  AHB system clock
HRESETn  input  1  asynchronous active-low reset
req_port  input  NUM_PORTS  per-input-stage request (input stage holds valid HSEL & HTRANS[1] for this slave)
HREADYM  input  1  slave-side HREADY; all state advances only when high
HTRANSM  input  2  HTRANS currently driven on slave port (from the granted port)
HBURSTM  input  3  HBURST currently driven on slave port
HMASTLOCKM  input  1  HMASTLOCK currently driven on slave port
addr_in_port  output  PORT_W  address-phase grant index
no_port  output  1  high when no port is granted (output stage drives IDLE)
data_in_port  output  PORT_W  data-phase grant index
data_in_valid  output  1  high when the current data phase belongs to a granted, non-IDLE transfer

Behaviour:
- Single clock HCLK. Reset HRESETn is asynchronous and active-low.
- Reset values: addr_in_port=0, no_port=1, data_in_port=0, data_in_valid=0, burst counter=0, rr pointer=0.
- All registers update only on a posedge where HREADYM=1. With HREADYM=0, every output and all state holds (wait states).
- hold = HMASTLOCKM | (HTRANSM==BUSY) | (beats_left!=0).
- Arbitration, when HREADYM=1 and hold=0:
  - Scan req_port starting at (addr_in_port+1) mod NUM_PORTS, wrapping.
  - The first set bit becomes the new addr_in_port, and no_port<=0.
  - The current holder is considered last. It keeps the grant if it is the only requester.
  - If no bit is set, no_port<=1 and addr_in_port holds its last value.
- Grant latency: a request seen at edge N becomes addr_in_port after edge N (one registered cycle).
- Burst tracker (beats_left, 4 bits):
  - On an accepted NONSEQ with HBURSTM in {WRAP4, INCR4}: load 3. {WRAP8, INCR8}: load 7. {WRAP16, INCR16}: load 15. SINGLE or INCR: load 0.
  - Decrement on each accepted SEQ while nonzero.
  - Undefined INCR is not held. Re-arbitration may occur between its beats, which is legal for AHB-Lite matrix slaves.
- Early termination: if beats_left!=0 and req_port[addr_in_port]=0 (master ended the burst, e.g. after an ERROR), clear beats_left and arbitrate normally on that edge.
- Lock: while HMASTLOCKM=1, the grant is held regardless of other requests. On an accepted IDLE that ends the locked sequence, release as normal.
- Data phase: on HREADYM=1, data_in_port<=addr_in_port and data_in_valid<=~no_port & HTRANSM[1].
- Simultaneous events: a new NONSEQ from the holder and a request from another port on the same edge with hold=0 → the other port wins (round-robin fairness). The holder's NONSEQ is not counted; the burst counter loads only for the port holding the grant during that address phase.
- NUM_PORTS not a power of two: the index wrap uses modulo NUM_PORTS, never PORT_W overflow.

Optional Feature:
L1AHBMTX_FIXED_PRIORITY_EN:
- Defined: the scan always starts at port 0, so the lowest index has highest priority. Hold rules are unchanged.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package l1ahbmtx_pkg:
  - HTRANS encodings: IDLE, BUSY, NONSEQ, SEQ.
  - HBURST encodings.
  - Function burst_beats(hburst) returning beats-1.
  - Localparam for beat-counter width.
- One sub-module, l1ahbmtx_burst_tracker: owns beats_left and the early-termination clear, and outputs burst_hold. The arbiter owns the scan and the grant registers.

Test Plan:
- Reset asserted mid-burst (beats_left=5) → same cycle: no_port=1, data_in_valid=0, addr_in_port=0; after release, fresh arbitration.
- req_port=4'b1111, SINGLE NONSEQs, HREADYM=1 every cycle → addr_in_port sequence 1,2,3,0,1; data_in_port lags by one cycle.
- Port 2 INCR8 NONSEQ then 7 SEQ with req_port=4'b1111 → addr_in_port stays 2 for all 8 beats, then moves to 3.
- Port 1 HMASTLOCKM=1 for 3 transfers with other ports requesting → grant stays 1 until the locked IDLE completes, then moves to 2.
- HREADYM=0 for 4 cycles while req_port changes → all outputs frozen; arbitration resumes on the first HREADYM=1 edge.
- Port 0 WRAP4 drops req after 2 beats → beats_left cleared, grant moves to the next requester on that edge. With L1AHBMTX_FIXED_PRIORITY_EN defined and req_port=4'b1010 → grant always 1.
